seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Multiplexed display controller that sits between the sensor readout logic and the per-digit 7-segment encoder. It accepts a humidity/temperature byte pair on a load strobe and converts both bytes to decimal with a sequential shift-add-3 (double-dabble) engine. It holds the four resulting digits in display registers and time-multiplexes them onto a common-segment, four-anode display. Each digit slot starts with a blanking interval to suppress ghosting.

## Interface
- REFRESH_DIV, 100000: clocks per digit slot; minimum 4.
- BLANK_CYCLES, 1000: clocks at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  single-cycle strobe; samples humidity/temperature.
- humidity  input  8  unsigned binary, expected range 0..99.
- temperature  input  8  unsigned binary, expected range 0..99.
- busy  output  1  high while a conversion is in flight.
- digit_code  output  4  code for the active digit, fed to the segment encoder; 4'd10 = blank (encoder outputs all segments off).
- anode  output  4  active-low digit enables, one-hot-low or 4'b1111.

## Operation
- Digit map: index 3 = humidity tens, 2 = humidity units, 1 = temperature tens, 0 = temperature units.
- Conversion FSM states:
  - IDLE: on load, capture both bytes into working registers, clear iteration counter, go to CONV.
  - CONV: one double-dabble iteration per clock, both bytes in parallel; add 3 to any BCD nibble ≥5, then shift left. After iteration 7, go to COMMIT.
  - COMMIT: write the four display registers, then go to IDLE, or to CONV if a load is pending.
- Range rule: a byte ≥100 writes code 4'd10 to both of its digits. The other pair is unaffected.
- Load while busy (CONV or COMMIT): load is never dropped.
  - Operands go to a one-deep shadow and pending is set; later loads overwrite the shadow (latest wins).
  - At COMMIT, if load is high that same cycle, its operands are used directly. Otherwise the shadow operands are used and pending clears.
- Scan:
  - slot counter runs 0..REFRESH_DIV-1.
  - At terminal count, the 2-bit digit index increments, wrapping 3→0.
  - anode = 4'b1111 while counter < BLANK_CYCLES; otherwise anode has bit[index] = 0 and all other bits 1.
  - digit_code always reflects the display register at the current index.
- The scan runs continuously and independently of conversion. A display update at COMMIT is visible on the next clock without restarting the slot.

## Timing
- Reset values:
  - state IDLE, busy 0, pending 0.
  - all display registers 4'd10, digit_code 4'd10.
  - anode 4'b1111, slot counter 0, digit index 0.
- Load sampled at edge k:
  - busy = 1 after edges k through k+8 (CONV iterations at edges k+1..k+8, COMMIT state after edge k+8).
  - Display registers update at edge k+9; busy = 0 after k+9 unless a load is pending.
  - Load-to-display latency: 9 clocks.
- Back-to-back conversions: COMMIT → CONV directly, with no IDLE cycle; busy stays high.
- Slot period: REFRESH_DIV clocks. Full refresh: 4·REFRESH_DIV clocks. Dark interval per slot: exactly BLANK_CYCLES clocks.
- Reset asserted mid-conversion or mid-slot: every register returns to its reset value at that edge, and the in-flight result is discarded.
- digit_code and anode are registered outputs; no combinational path from inputs.

## Test plan
- Reset with REFRESH_DIV = 8, BLANK_CYCLES = 2: anode = 1111 and digit_code = 10 for every slot.
  - After the first index wrap, anode reads 1111 (2 clocks), then 1110 (6 clocks), then 1111 (2 clocks), then 1101 (6 clocks), and so on.
- load with humidity = 45, temperature = 23: busy high for exactly 9 clocks.
  - Display registers then hold 4, 5, 2, 3 for indices 3..0.
  - digit_code reads 3 during the active part of slot 0 and 4 in slot 3.
- humidity = 120, temperature = 7: indices 3,2 = 10 (blank); indices 1,0 = 0, 7.
  - Edge values 0 and 99 give 0,0 and 9,9.
- Loads at k (50/20), k+3 (60/21), k+5 (70/22): first commit at k+9 shows 5,0,2,0.
  - busy stays high; second commit at k+18 shows 7,0,2,2; busy low after k+18.
- Load at edge k+9 of a running conversion: busy stays high and the new value commits at k+18.
- Reset asserted at k+4 of a conversion: busy = 0 and all digits 10 afterward.
  - A fresh load of 12/34 then commits 9 clocks later.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display controller: double-dabble conversion of a
// humidity/temperature byte pair, with blanked, time-multiplexed anode scanning.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  output logic       busy,
  output logic [3:0] digit_code,
  output logic [3:0] anode
);

  localparam int             CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  CNT_BLANK  = CW'(BLANK_CYCLES);
  localparam logic [3:0]     CODE_BLANK = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // One double-dabble step on {hundreds, tens, units, binary}.
  function automatic logic [19:0] dd_step(input logic [19:0] w);
    logic [19:0] a;
    a = w;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    else                  a[11:8]  = a[11:8];
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    else                  a[15:12] = a[15:12];
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    else                  a[19:16] = a[19:16];
    return {a[18:0], 1'b0};
  endfunction

  // A non-zero hundreds digit means the byte is out of display range.
  function automatic logic [7:0] to_codes(input logic [11:0] bcd);
    if (bcd[11:8] != 4'd0) return {CODE_BLANK, CODE_BLANK};
    else                   return bcd[7:0];
  endfunction

  state_t          state, state_nx;
  logic [19:0]     hum_w, hum_nx, tmp_w, tmp_nx;
  logic [2:0]      iter, iter_nx;
  logic            pending, pending_nx;
  logic [7:0]      sh_hum, sh_hum_nx, sh_tmp, sh_tmp_nx;
  logic [3:0][3:0] disp, disp_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      idx, idx_nx;

  assign busy = (state != IDLE);

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_nx   = state;
    hum_nx     = hum_w;
    tmp_nx     = tmp_w;
    iter_nx    = iter;
    pending_nx = pending;
    sh_hum_nx  = sh_hum;
    sh_tmp_nx  = sh_tmp;
    disp_nx    = disp;
    case (state)
      IDLE: begin
        if (load) begin
          hum_nx   = {12'd0, humidity};
          tmp_nx   = {12'd0, temperature};
          iter_nx  = 3'd0;
          state_nx = CONV;
        end else begin
          state_nx = IDLE;
        end
      end
      CONV: begin
        hum_nx  = dd_step(hum_w);
        tmp_nx  = dd_step(tmp_w);
        iter_nx = iter + 3'd1;
        if (iter == 3'd7) state_nx = COMMIT;
        else              state_nx = CONV;
        if (load) begin
          sh_hum_nx  = humidity;
          sh_tmp_nx  = temperature;
          pending_nx = 1'b1;
        end else begin
          pending_nx = pending;
        end
      end
      COMMIT: begin
        disp_nx    = {to_codes(hum_w[19:8]), to_codes(tmp_w[19:8])};
        pending_nx = 1'b0;
        iter_nx    = 3'd0;
        // A load in this very cycle is newer than anything in the shadow.
        if (load) begin
          hum_nx   = {12'd0, humidity};
          tmp_nx   = {12'd0, temperature};
          state_nx = CONV;
        end else if (pending) begin
          hum_nx   = {12'd0, sh_hum};
          tmp_nx   = {12'd0, sh_tmp};
          state_nx = CONV;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx   = IDLE;
        pending_nx = 1'b0;
      end
    endcase
  end

  // Slot counter and digit index advance.
  always_comb begin
    cnt_nx = cnt + CW'(1);
    idx_nx = idx;
    if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      idx_nx = idx + 2'd1;
    end else begin
      cnt_nx = cnt + CW'(1);
      idx_nx = idx;
    end
  end

  // State, datapath and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hum_w      <= 20'd0;
      tmp_w      <= 20'd0;
      iter       <= 3'd0;
      pending    <= 1'b0;
      sh_hum     <= 8'd0;
      sh_tmp     <= 8'd0;
      disp       <= {4{CODE_BLANK}};
      cnt        <= '0;
      idx        <= 2'd0;
      digit_code <= CODE_BLANK;
      anode      <= 4'b1111;
    end else begin
      state      <= state_nx;
      hum_w      <= hum_nx;
      tmp_w      <= tmp_nx;
      iter       <= iter_nx;
      pending    <= pending_nx;
      sh_hum     <= sh_hum_nx;
      sh_tmp     <= sh_tmp_nx;
      disp       <= disp_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      // Outputs track the values being written so updates show without lag.
      digit_code <= disp_nx[idx_nx];
      anode      <= (cnt_nx < CNT_BLANK) ? 4'b1111 : ~(4'b0001 << idx_nx);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a cycle-count based reference model.
module tb_seg_scan_ctrl;
  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst, load;
  logic [7:0] humidity, temperature;
  logic       busy;
  logic [3:0] digit_code, anode;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_active, m_pend;
  int m_commit_at, m_cur_h, m_cur_t, m_pend_h, m_pend_t;
  int m_disp[4];
  int scan_t, edge_n;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .humidity(humidity),
    .temperature(temperature), .busy(busy), .digit_code(digit_code), .anode(anode)
  );

  always #5 clk = ~clk;

  function automatic int code_of(int v, bit tens);
    if (v >= 100) return 10;
    return tens ? v / 10 : v % 10;
  endfunction

  function automatic void m_apply(int h, int t);
    m_disp[3] = code_of(h, 1'b1);
    m_disp[2] = code_of(h, 1'b0);
    m_disp[1] = code_of(t, 1'b1);
    m_disp[0] = code_of(t, 1'b0);
  endfunction

  function automatic int cur_idx();
    return (scan_t / RD) % 4;
  endfunction

  function automatic logic [3:0] exp_anode();
    logic [3:0] a;
    a = 4'b1111;
    if (scan_t % RD >= BC) a[cur_idx()] = 1'b0;
    return a;
  endfunction

  // Drive inputs on the falling edge, advance the model at the rising edge.
  task automatic tick(input bit r, input bit ld, input int h, input int t);
    @(negedge clk);
    rst = r; load = ld; humidity = 8'(h); temperature = 8'(t);
    @(posedge clk);
    if (r) begin
      m_active = 1'b0; m_pend = 1'b0; scan_t = 0; edge_n = 0;
      for (int i = 0; i < 4; i++) m_disp[i] = 10;
    end else begin
      edge_n++; scan_t++;
      if (m_active && edge_n == m_commit_at) begin
        m_apply(m_cur_h, m_cur_t);
        if (ld) begin
          m_cur_h = h; m_cur_t = t; m_pend = 1'b0; m_commit_at = edge_n + 9;
        end else if (m_pend) begin
          m_cur_h = m_pend_h; m_cur_t = m_pend_t; m_pend = 1'b0; m_commit_at = edge_n + 9;
        end else begin
          m_active = 1'b0;
        end
      end else if (m_active) begin
        if (ld) begin m_pend = 1'b1; m_pend_h = h; m_pend_t = t; end
      end else if (ld) begin
        m_active = 1'b1; m_cur_h = h; m_cur_t = t; m_commit_at = edge_n + 9;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 0, 0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (anode !== 4'b1111) begin n_fail++; $display("FAIL reset_anode got=%b exp=1111", anode); end
    n_tests++; if (digit_code !== 4'd10) begin n_fail++; $display("FAIL reset_code got=%0d exp=10", digit_code); end
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0, 0, 0);
      n_tests++;
      if (anode !== exp_anode()) begin n_fail++; $display("FAIL reset_scan_anode t=%0d got=%b exp=%b", scan_t, anode, exp_anode()); end
      n_tests++;
      if (digit_code !== 4'd10) begin n_fail++; $display("FAIL reset_scan_code t=%0d got=%0d exp=10", scan_t, digit_code); end
    end
  endtask

  task automatic test_convert(input int h, input int t);
    int e[4];
    e[3] = code_of(h, 1'b1); e[2] = code_of(h, 1'b0);
    e[1] = code_of(t, 1'b1); e[0] = code_of(t, 1'b0);
    tick(1'b0, 1'b1, h, t);
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 0, 0);
      n_tests++;
      if (busy !== (i < 9)) begin n_fail++; $display("FAIL conv_busy %0d/%0d step=%0d got=%b", h, t, i, busy); end
    end
    for (int i = 0; i < 4 * RD; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 0, 0);
      n_tests++;
      if (digit_code !== 4'(e[cur_idx()])) begin
        n_fail++; $display("FAIL conv_code %0d/%0d idx=%0d got=%0d exp=%0d", h, t, cur_idx(), digit_code, e[cur_idx()]);
      end
      n_tests++;
      if (anode !== exp_anode()) begin n_fail++; $display("FAIL conv_anode got=%b exp=%b", anode, exp_anode()); end
    end
  endtask

  task automatic test_back_to_back();
    int a1[4] = '{0, 2, 0, 5};
    int a2[4] = '{2, 2, 0, 7};
    for (int e = 0; e <= 18; e++) begin
      case (e)
        0: tick(1'b0, 1'b1, 50, 20);
        3: tick(1'b0, 1'b1, 60, 21);
        5: tick(1'b0, 1'b1, 70, 22);
        default: tick(1'b0, 1'b0, 0, 0);
      endcase
      n_tests++;
      if (busy !== (e < 18)) begin n_fail++; $display("FAIL b2b_busy e=%0d got=%b", e, busy); end
      if (e >= 9 && e < 18) begin
        n_tests++;
        if (digit_code !== 4'(a1[cur_idx()])) begin n_fail++; $display("FAIL b2b_first e=%0d got=%0d exp=%0d", e, digit_code, a1[cur_idx()]); end
      end
      if (e == 18) begin
        n_tests++;
        if (digit_code !== 4'(a2[cur_idx()])) begin n_fail++; $display("FAIL b2b_second got=%0d exp=%0d", digit_code, a2[cur_idx()]); end
      end
    end
  endtask

  task automatic test_load_at_commit();
    int a1[4] = '{4, 4, 3, 3};
    int a2[4] = '{9, 0, 1, 8};
    for (int e = 0; e <= 18; e++) begin
      if (e == 0)      tick(1'b0, 1'b1, 33, 44);
      else if (e == 9) tick(1'b0, 1'b1, 81, 9);
      else             tick(1'b0, 1'b0, 0, 0);
      n_tests++;
      if (busy !== (e < 18)) begin n_fail++; $display("FAIL commit_load_busy e=%0d got=%b", e, busy); end
      if (e >= 9 && e < 18) begin
        n_tests++;
        if (digit_code !== 4'(a1[cur_idx()])) begin n_fail++; $display("FAIL commit_load_first e=%0d got=%0d exp=%0d", e, digit_code, a1[cur_idx()]); end
      end
      if (e == 18) begin
        n_tests++;
        if (digit_code !== 4'(a2[cur_idx()])) begin n_fail++; $display("FAIL commit_load_second got=%0d exp=%0d", digit_code, a2[cur_idx()]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int a[4] = '{4, 3, 2, 1};
    tick(1'b0, 1'b1, 88, 77);
    for (int i = 1; i < 4; i++) tick(1'b0, 1'b0, 0, 0);
    tick(1'b1, 1'b0, 0, 0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_tests++; if (anode !== 4'b1111) begin n_fail++; $display("FAIL midrst_anode got=%b exp=1111", anode); end
    for (int i = 0; i < 4 * RD; i++) begin
      tick(1'b0, 1'b0, 0, 0);
      n_tests++;
      if (busy !== 1'b0 || digit_code !== 4'd10) begin
        n_fail++; $display("FAIL midrst_discard i=%0d busy=%b code=%0d exp busy=0 code=10", i, busy, digit_code);
      end
    end
    tick(1'b0, 1'b1, 12, 34);
    for (int i = 1; i <= 9; i++) tick(1'b0, 1'b0, 0, 0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_fresh_busy got=%b exp=0", busy); end
    for (int i = 0; i < 4 * RD; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 0, 0);
      n_tests++;
      if (digit_code !== 4'(a[cur_idx()])) begin n_fail++; $display("FAIL midrst_fresh_code got=%0d exp=%0d", digit_code, a[cur_idx()]); end
    end
  endtask

  task automatic test_random();
    int h, t;
    bit ld;
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, (i < 300) ? 5 : 1) == 0);
      h = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 99);
      t = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 99);
      tick(1'b0, ld, h, t);
      n_tests++;
      if (busy !== m_active) begin n_fail++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, m_active); end
      n_tests++;
      if (digit_code !== 4'(m_disp[cur_idx()])) begin
        n_fail++; $display("FAIL rnd_code i=%0d got=%0d exp=%0d", i, digit_code, m_disp[cur_idx()]);
      end
      n_tests++;
      if (anode !== exp_anode()) begin n_fail++; $display("FAIL rnd_anode i=%0d got=%b exp=%b", i, anode, exp_anode()); end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; humidity = 8'd0; temperature = 8'd0;
    test_reset();
    test_convert(45, 23);
    test_convert(120, 7);
    test_convert(0, 99);
    test_convert(99, 0);
    test_back_to_back();
    test_load_at_commit();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
